// File: rtl/snes_input_arbiter_pkg.sv
// Shared types and constants for the SNES input arbiter: source/owner codes,
// DIP mode codes, FSM states and the auto-mode arbitration priority.
package snes_arb_pkg;

    // Source currently driving the encoder word.
    typedef enum logic [1:0] {
        NONE = 2'b00,
        KB   = 2'b01,
        IR   = 2'b10,
        BTN  = 2'b11
    } owner_t;

    // NOTE: state codes deliberately match owner_t codes, so a grant or an
    // owner readout is a plain cast with no translation table.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        OWN_KB  = 2'b01,
        OWN_IR  = 2'b10,
        OWN_BTN = 2'b11
    } arb_state_t;

    // DIP switch mode codes.
    localparam logic [1:0] MODE_KB   = 2'b00;
    localparam logic [1:0] MODE_IR   = 2'b01;
    localparam logic [1:0] MODE_BTN  = 2'b10;
    localparam logic [1:0] MODE_AUTO = 2'b11;

    // Arbitration order for simultaneous activity, highest priority first.
    localparam owner_t ARB_PRIO [3] = '{BTN, KB, IR};

    // Highest-priority active source; act is indexed by owner_t code.
    function automatic owner_t pick_owner(input logic [3:0] act);
        owner_t pick;
        pick = NONE;
        // Walk from lowest to highest priority so the last hit wins.
        for (int i = 2; i >= 0; i--) begin
            if (act[ARB_PRIO[i]]) pick = ARB_PRIO[i];
        end
        return pick;
    endfunction

    // Source shown in a manual DIP mode.
    function automatic owner_t mode_owner(input logic [1:0] mode);
        owner_t o;
        case (mode)
            MODE_KB:  o = KB;
            MODE_IR:  o = IR;
            MODE_BTN: o = BTN;
            default:  o = NONE;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/snes_input_arbiter_if.sv
// Source-side and encoder-side signals of the SNES input arbiter. The master
// modport is the driver of the decoded words and mode; the slave modport is
// the arbiter itself.
interface snes_input_arbiter_if;

    logic [7:0] kb_word;
    logic       kb_avail;
    logic [7:0] ir_word;
    logic       ir_avail;
    logic [7:0] btn_word;
    logic [1:0] dip;
    logic [7:0] mux_out;
    logic [1:0] owner;
    logic       frame_tick;

    modport master (
        output kb_word, kb_avail, ir_word, ir_avail, btn_word, dip,
        input  mux_out, owner, frame_tick
    );

    modport slave (
        input  kb_word, kb_avail, ir_word, ir_avail, btn_word, dip,
        output mux_out, owner, frame_tick
    );

endinterface

// File: rtl/snes_input_arbiter_press_hold.sv
// Converts a one-cycle decoder event into a button press held for a fixed
// number of frames. Also flags that a fresh press arrived in this frame.
module press_hold #(
    parameter int PRESS_FRAMES = 6
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       avail_i,
    input  logic [7:0] word_i,
    input  logic       tick_i,
    output logic [7:0] lvl_o,
    output logic       active_o
);

    localparam int CW = $clog2(PRESS_FRAMES + 1);

    logic [7:0]    hold_q,   hold_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic          active_q, active_d;

    // Reload on a new event, clear on a release event, else count frames down.
    always_comb begin
        // NOTE: every next-state value gets its hold default first, so no
        // path through the block leaves it unassigned and infers a latch.
        hold_d   = hold_q;
        cnt_d    = cnt_q;
        active_d = active_q;

        // The arbiter has consumed this frame's activity at the tick.
        if (tick_i) active_d = 1'b0;

        if (avail_i) begin
            if (word_i != '0) begin
                // A reload on a tick cycle skips that tick's decrement, and
                // its activity counts toward the next frame.
                hold_d   = word_i;
                cnt_d    = CW'(PRESS_FRAMES);
                active_d = 1'b1;
            end else begin
                hold_d = '0;
                cnt_d  = '0;
            end
        end else if (tick_i && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Hold word, frame counter and activity flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q   <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            hold_q   <= hold_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign lvl_o    = (cnt_q != '0) ? hold_q : 8'h00;
    assign active_o = active_q;

endmodule

// File: rtl/snes_input_arbiter.sv
// Frame-synchronous selector for the SNES encoder word. Keyboard and IR events
// become timed presses; the word handed to the encoder changes only on a
// console latch boundary, either from a DIP-selected source or from an
// auto-mode owner chosen by activity.
module snes_input_arbiter
    import snes_arb_pkg::*;
#(
    parameter int PRESS_FRAMES = 6,
    parameter int IDLE_FRAMES  = 60,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 snes_latch,
    snes_input_arbiter_if.slave  arb
);

    localparam int IW = $clog2(IDLE_FRAMES + 1);

    // ---------------------------------------------------------------------
    // Latch synchronizer and rising-edge detector
    // ---------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q,  sync_d;
    logic [SYNC_STAGES-1:0] fill_q,  fill_d;
    logic                   prev_q,  prev_d;
    logic                   armed_q, armed_d;
    logic                   tick_q,  tick_d;
    logic                   latch_s;

    assign latch_s = sync_q[SYNC_STAGES-1];

    // Shift the latch in; arm the edge detector only once a real low sample
    // has come through, so a latch already high at reset release never ticks.
    always_comb begin
        sync_d  = SYNC_STAGES'({sync_q, snes_latch});
        fill_d  = SYNC_STAGES'({fill_q, 1'b1});
        prev_d  = latch_s;
        armed_d = armed_q | (fill_q[SYNC_STAGES-1] & ~latch_s);
        tick_d  = armed_q & latch_s & ~prev_q;
    end

    // Synchronizer, fill tracker, edge-detect and frame tick registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            fill_q  <= '0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            fill_q  <= fill_d;
            prev_q  <= prev_d;
            armed_q <= armed_d;
            tick_q  <= tick_d;
        end
    end

    // ---------------------------------------------------------------------
    // Keyboard and IR press registers
    // ---------------------------------------------------------------------
    logic [7:0] kb_lvl, ir_lvl;
    logic       kb_act, ir_act, btn_act;

    press_hold #(.PRESS_FRAMES(PRESS_FRAMES)) u_kb_hold (
        .clk      (clk),
        .reset_n  (reset_n),
        .avail_i  (arb.kb_avail),
        .word_i   (arb.kb_word),
        .tick_i   (tick_q),
        .lvl_o    (kb_lvl),
        .active_o (kb_act)
    );

    press_hold #(.PRESS_FRAMES(PRESS_FRAMES)) u_ir_hold (
        .clk      (clk),
        .reset_n  (reset_n),
        .avail_i  (arb.ir_avail),
        .word_i   (arb.ir_word),
        .tick_i   (tick_q),
        .lvl_o    (ir_lvl),
        .active_o (ir_act)
    );

    assign btn_act = (arb.btn_word != 8'h00);

    // ---------------------------------------------------------------------
    // Mode select, auto-mode ownership FSM and output word
    // ---------------------------------------------------------------------
    arb_state_t    state_q, state_d;
    logic [IW-1:0] idle_q,  idle_d;
    logic [7:0]    mux_q,   mux_d;
    owner_t        owner_q, owner_d;
    logic [3:0]    act;

    assign act = {btn_act, ir_act, kb_act, 1'b0};

    function automatic logic [7:0] level_of(input owner_t o, input logic [7:0] kb,
                                            input logic [7:0] ir, input logic [7:0] btn);
        logic [7:0] lvl;
        case (o)
            KB:      lvl = kb;
            IR:      lvl = ir;
            BTN:     lvl = btn;
            default: lvl = 8'h00;
        endcase
        return lvl;
    endfunction

    // At each frame tick pick the next owner and the word for the new frame;
    // between ticks everything holds so the word is stable across a shift.
    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        mux_d   = mux_q;
        owner_d = owner_q;

        if (tick_q) begin
            if (arb.dip == MODE_AUTO) begin
                case (state_q)
                    IDLE: begin
                        state_d = arb_state_t'(pick_owner(act));
                        idle_d  = '0;
                    end
                    default: begin
                        // Only the owner's activity counts; others are ignored.
                        if (act[state_q]) begin
                            idle_d = '0;
                        end else if (idle_q == IW'(IDLE_FRAMES)) begin
                            state_d = IDLE;
                            idle_d  = '0;
                        end else begin
                            idle_d = idle_q + 1'b1;
                        end
                    end
                endcase
                owner_d = owner_t'(state_d);
            end else begin
                // Manual modes park the FSM so auto entry starts clean.
                state_d = IDLE;
                idle_d  = '0;
                owner_d = mode_owner(arb.dip);
            end
            mux_d = level_of(owner_d, kb_lvl, ir_lvl, arb.btn_word);
        end
    end

    // FSM state, idle counter and registered encoder outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idle_q  <= '0;
            mux_q   <= 8'h00;
            owner_q <= NONE;
        end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
            mux_q   <= mux_d;
            owner_q <= owner_d;
        end
    end

    assign arb.mux_out    = mux_q;
    assign arb.owner      = owner_q;
    assign arb.frame_tick = tick_q;

endmodule

// File: tb/tb_snes_input_arbiter.sv
// Directed bench for snes_input_arbiter: manual hold timing, retrigger,
// reload/tick coincidence, auto priority, auto release and mid-frame reset.
module tb_snes_input_arbiter;

    logic clk;
    logic reset_n;
    logic snes_latch;

    int n_cmp = 0;
    int n_bad = 0;
    int lat;

    snes_input_arbiter_if bus ();

    snes_input_arbiter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .snes_latch (snes_latch),
        .arb        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One console latch: raise it, wait (bounded) for frame_tick, optionally
    // land a kb event on the tick cycle, then let the frame settle.
    task automatic run_frame(input logic co_kb, input logic [7:0] co_word, output int latency);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        @(negedge clk);
        snes_latch = 1'b1;
        while (!seen && n < 12) begin
            @(negedge clk);
            n++;
            if (bus.frame_tick === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL frame_tick_timeout: no tick after %0d cycles, required within 12", n);
        end
        latency = seen ? n : -1;
        if (seen && co_kb) begin
            bus.kb_word  = co_word;
            bus.kb_avail = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.kb_avail = 1'b0;
        snes_latch   = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_kb(input logic [7:0] w);
        @(negedge clk);
        bus.kb_word  = w;
        bus.kb_avail = 1'b1;
        @(negedge clk);
        bus.kb_avail = 1'b0;
    endtask

    task automatic pulse_ir(input logic [7:0] w);
        @(negedge clk);
        bus.ir_word  = w;
        bus.ir_avail = 1'b1;
        @(negedge clk);
        bus.ir_avail = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.mux_out !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_mux: got %h expected 00", bus.mux_out);
        end
        n_cmp++;
        if (bus.owner !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_owner: got %b expected 00", bus.owner);
        end
        n_cmp++;
        if (bus.frame_tick !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_tick: got %b expected 0", bus.frame_tick);
        end
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_manual_kb;
        logic [7:0] exp;
        bus.dip = 2'b00;
        pulse_kb(8'h10);
        for (int f = 1; f <= 7; f++) begin
            run_frame(1'b0, 8'h00, lat);
            if (f == 1) begin
                n_cmp++;
                if (lat !== 3) begin
                    n_bad++;
                    $display("FAIL tick_latency: got %0d cycles expected 3", lat);
                end
                n_cmp++;
                if (bus.owner !== 2'b01) begin
                    n_bad++;
                    $display("FAIL manual_kb_owner: got %b expected 01", bus.owner);
                end
            end
            exp = (f <= 6) ? 8'h10 : 8'h00;
            n_cmp++;
            if (bus.mux_out !== exp) begin
                n_bad++;
                $display("FAIL manual_kb f%0d: got %h expected %h", f, bus.mux_out, exp);
            end
        end
    endtask

    task automatic test_retrigger;
        logic [7:0] exp;
        bus.dip = 2'b01;
        pulse_ir(8'h04);
        for (int f = 0; f <= 11; f++) begin
            if (f == 4) pulse_ir(8'h04);
            run_frame(1'b0, 8'h00, lat);
            exp = (f <= 9) ? 8'h04 : 8'h00;
            n_cmp++;
            if (bus.mux_out !== exp) begin
                n_bad++;
                $display("FAIL retrigger f%0d: got %h expected %h", f, bus.mux_out, exp);
            end
        end
        n_cmp++;
        if (bus.owner !== 2'b10) begin
            n_bad++;
            $display("FAIL retrigger_owner: got %b expected 10", bus.owner);
        end
    endtask

    task automatic test_coincident;
        logic [7:0] exp;
        bus.dip = 2'b00;
        run_frame(1'b1, 8'h10, lat);
        n_cmp++;
        if (bus.mux_out !== 8'h00) begin
            n_bad++;
            $display("FAIL coincident_tick_frame: got %h expected 00", bus.mux_out);
        end
        for (int f = 1; f <= 7; f++) begin
            run_frame(1'b0, 8'h00, lat);
            exp = (f <= 6) ? 8'h10 : 8'h00;
            n_cmp++;
            if (bus.mux_out !== exp) begin
                n_bad++;
                $display("FAIL coincident f%0d: got %h expected %h", f, bus.mux_out, exp);
            end
        end
    endtask

    task automatic test_auto_priority;
        bus.dip      = 2'b11;
        bus.btn_word = 8'h01;
        for (int f = 0; f < 5; f++) begin
            pulse_kb(8'h80);
            run_frame(1'b0, 8'h00, lat);
            n_cmp++;
            if (bus.owner !== 2'b11) begin
                n_bad++;
                $display("FAIL prio_owner f%0d: got %b expected 11", f, bus.owner);
            end
            n_cmp++;
            if (bus.mux_out !== 8'h01) begin
                n_bad++;
                $display("FAIL prio_mux f%0d: got %h expected 01", f, bus.mux_out);
            end
        end
        // Park in a manual mode for one frame so auto re-entry starts in IDLE.
        bus.btn_word = 8'h00;
        bus.dip      = 2'b00;
        run_frame(1'b0, 8'h00, lat);
    endtask

    task automatic test_auto_release;
        bus.dip = 2'b11;
        pulse_ir(8'h02);
        run_frame(1'b0, 8'h00, lat);
        n_cmp++;
        if (bus.owner !== 2'b10 || bus.mux_out !== 8'h02) begin
            n_bad++;
            $display("FAIL release_grant: got owner %b mux %h expected 10 02", bus.owner, bus.mux_out);
        end
        for (int f = 1; f <= 60; f++) begin
            pulse_kb(8'h20);
            run_frame(1'b0, 8'h00, lat);
            n_cmp++;
            if (bus.owner !== 2'b10) begin
                n_bad++;
                $display("FAIL release_hold f%0d: got owner %b expected 10", f, bus.owner);
            end
        end
        pulse_kb(8'h20);
        run_frame(1'b0, 8'h00, lat);
        n_cmp++;
        if (bus.owner !== 2'b00 || bus.mux_out !== 8'h00) begin
            n_bad++;
            $display("FAIL release_frame: got owner %b mux %h expected 00 00", bus.owner, bus.mux_out);
        end
        pulse_kb(8'h20);
        run_frame(1'b0, 8'h00, lat);
        n_cmp++;
        if (bus.owner !== 2'b01 || bus.mux_out !== 8'h20) begin
            n_bad++;
            $display("FAIL release_regrant: got owner %b mux %h expected 01 20", bus.owner, bus.mux_out);
        end
    endtask

    task automatic test_reset_midframe;
        int ticks;
        int n;
        bit seen;
        @(negedge clk);
        snes_latch = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.mux_out !== 8'h00 || bus.owner !== 2'b00 || bus.frame_tick !== 1'b0) begin
            n_bad++;
            $display("FAIL midframe_reset: got mux %h owner %b tick %b expected 00 00 0",
                     bus.mux_out, bus.owner, bus.frame_tick);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        ticks = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.frame_tick === 1'b1) ticks++;
        end
        n_cmp++;
        if (ticks !== 0) begin
            n_bad++;
            $display("FAIL high_latch_release: got %0d ticks expected 0", ticks);
        end
        snes_latch = 1'b0;
        repeat (5) @(negedge clk);
        snes_latch = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 12) begin
            @(negedge clk);
            n++;
            if (bus.frame_tick === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen || n !== 3) begin
            n_bad++;
            $display("FAIL fresh_edge_tick: got seen %0d after %0d cycles expected seen 1 after 3", seen, n);
        end
        @(negedge clk);
        snes_latch = 1'b0;
    endtask

    initial begin
        reset_n      = 1'b0;
        snes_latch   = 1'b0;
        bus.kb_word  = 8'h00;
        bus.kb_avail = 1'b0;
        bus.ir_word  = 8'h00;
        bus.ir_avail = 1'b0;
        bus.btn_word = 8'h00;
        bus.dip      = 2'b00;

        test_reset();
        test_manual_kb();
        test_retrigger();
        test_coincident();
        test_auto_priority();
        test_auto_release();
        test_reset_midframe();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/snes_input_arbiter.md
# snes_input_arbiter

Frame-synchronous controller that shares the SNES encoder's 8-bit button word between the keyboard decoder, IR decoder and button board. It replaces the static DIP mux with a sequenced selector that:
- converts keyboard/IR event pulses into timed button presses;
- grants ownership among sources in auto mode;
- updates the encoder's word only on console latch boundaries, so a word never changes mid-shift.

## Interface
Parameters:
- PRESS_FRAMES, default 6: frames a kb/IR event is held as pressed.
- IDLE_FRAMES, default 60: inactive frames before an auto-mode owner is released.
- SYNC_STAGES, default 2: flops in the snes_latch synchronizer.

Ports:
- clk  in  1  system clock, 2.08 MHz oscillator domain.
- reset_n  in  1  asynchronous, active-low reset.
- snes_latch  in  1  console latch, asynchronous to clk.
- kb_word  in  8  decoded keyboard button word, active-high.
- kb_avail  in  1  one-cycle pulse: kb_word is valid.
- ir_word  in  8  decoded IR button word, active-high.
- ir_avail  in  1  one-cycle pulse: ir_word is valid.
- btn_word  in  8  button board level, active-high (already inverted).
- dip  in  2  mode: 00 kb, 01 IR, 10 buttons, 11 auto.
- mux_out  out  8  word to snes_encoder d input.
- owner  out  2  current source: 00 none, 01 kb, 10 IR, 11 buttons.
- frame_tick  out  1  one-cycle pulse per detected latch rising edge.

## Operation
- **Frame tick.** snes_latch passes through SYNC_STAGES flops, then a rising-edge detect produces frame_tick.
- **kb/IR press registers.** One per source: hold word plus counter, width clog2(PRESS_FRAMES+1).
  - avail with nonzero word: load hold word, set counter to PRESS_FRAMES, flag the source active for this frame.
  - avail with zero word: clear hold and counter immediately; not activity.
  - frame_tick with counter > 0: decrement counter. When counter reaches 0, the effective level is 0.
  - avail and frame_tick in the same cycle: the reload wins, with no decrement that cycle.
- **Effective level.** kb_lvl and ir_lvl are the hold word while the counter is nonzero, else 0. Button activity means btn_word != 0 when sampled at frame_tick.
- **Manual modes (dip 00/01/10).**
  - At each frame_tick, mux_out takes the selected source's level.
  - owner shows the selected source.
  - FSM is forced to IDLE; press counters keep running.
- **Auto mode FSM.** States are IDLE, OWN_KB, OWN_IR, OWN_BTN. Evaluation happens only at frame_tick.
  - IDLE: if any source was active this frame, grant it. Simultaneous activity uses priority btn > kb > ir.
  - OWN_x: owner activity clears the idle counter. Otherwise the idle counter increments, saturating at IDLE_FRAMES.
  - OWN_x with idle counter == IDLE_FRAMES: go to IDLE. The release frame outputs 0.
  - Non-owner activity is ignored while OWN_x.
  - Output is the owner's level; 0 in IDLE.
- **Mode changes.** A dip change takes effect at the next frame_tick. Entering auto starts in IDLE with the idle counter at 0.
- **Activity flags.** Cleared at every frame_tick after evaluation.

## Timing
- Reset: mux_out=0, owner=00, frame_tick=0, all counters/holds=0, FSM=IDLE, sync flops=0.
- Latch edge to frame_tick: SYNC_STAGES+1 clk cycles.
- mux_out and owner update on the clk edge after frame_tick and stay stable for the whole frame.
- The encoder loads mux_out on the next console latch, so input-to-console latency is one frame.
- reset_n asserted mid-frame: outputs go to reset values immediately. The first frame_tick after release requires a fresh rising edge; a latch already high at release produces no tick.
- Latch pulses shorter than one clk period are not guaranteed to be detected.

## Structure
- Shared package snes_arb_pkg holds:
  - owner_t enum (NONE, KB, IR, BTN = 2'b00..2'b11);
  - mode constants MODE_KB, MODE_IR, MODE_BTN, MODE_AUTO;
  - arbitration priority order.
- Sub-module press_hold holds the hold word, counter and reload/decrement rule. It is instantiated twice, for kb and IR.
- Synchronizer and edge detect are inline.

## Test plan
- Manual kb mode: kb_avail pulse with kb_word=8'h10, then 7 latches. mux_out must be 8'h10 for exactly 6 frames, then 8'h00.
- Retrigger: IR mode, ir_word=8'h04 pulsed at frame 0 and again at frame 4. mux_out must be 8'h04 through frame 9, then 0 at frame 10.
- Auto priority: btn_word=8'h01 and a kb pulse of 8'h80 in the same frame. owner must be 11 and mux_out 8'h01; the kb word never appears while btn stays active.
- Auto release: IR owns, then no IR activity for 60 frames while kb pulses every frame. owner must be 10 until release, 00 for one frame with mux_out=0, then 01.
- avail and tick coincident: a kb pulse on the same cycle as frame_tick must give the counter PRESS_FRAMES, not PRESS_FRAMES−1.
- Reset mid-frame with latch held high: all outputs must be 0. No frame_tick until latch falls and rises again.
